// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch path.
// A queue entry pairs a fetched word with the address it was fetched from.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Fetches are always word aligned, so redirect targets lose their low two bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with a combinational head and a flush input.
// Flush has priority over push and pop in the same cycle.
module if_sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  T                             i_data,
  input  logic                         i_pop,
  output T                             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !i_clear && !o_full;
  assign w_pop  = i_pop  && !i_clear && !o_empty;

  // DEPTH is a power of two, so pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetcher: issues in-order word fetches, queues {pc, instr}
// responses and hands the head to decode; a redirect flushes and drops in-flight data.
module if_prefetch_buffer
  import if_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] pctarget,
  input  logic            stall_d,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_full;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [31:0]     w_slots_used;
  logic            w_issue;
  logic            w_resp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [OW-1:0]   w_outstanding_next;

  // Outstanding requests hold a queue slot so a response can always be accepted.
  assign w_slots_used = 32'(w_count) + 32'(r_outstanding);

  assign imem_req  = rst && !pcsrc
                   && (r_outstanding < OW'(MAX_OUTSTANDING))
                   && (w_slots_used < 32'(DEPTH));
  assign imem_addr = r_fetch_pc;

  assign w_issue = imem_req && imem_gnt;
  assign w_resp  = imem_rvalid && (r_outstanding != '0);
  assign w_drop  = w_resp && (r_discard != '0);
  assign w_push  = w_resp && !w_drop && !pcsrc;
  assign w_pop   = instr_valid && !stall_d;

  assign w_outstanding_next = r_outstanding + OW'(w_issue) - OW'(w_resp);

  assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata};

  if_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (pcsrc),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign instr_valid = !w_empty && !pcsrc;

  always_comb begin
    instruction = NOP_INSTR;
    pc          = '0;
    pc4         = '0;
    if (!w_empty) begin
      instruction = w_head.instr;
      pc          = w_head.pc;
      pc4         = w_head.pc + XLEN'(4);
    end
  end

  // On redirect every request still in flight, including one granted this
  // cycle, is marked for discard; a response arriving this cycle is dropped too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (pcsrc) begin
        r_fetch_pc <= align_word(pctarget);
        r_resp_pc  <= align_word(pctarget);
        r_discard  <= w_outstanding_next;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)  r_resp_pc  <= r_resp_pc + XLEN'(4);
        if (w_drop)  r_discard  <= r_discard - OW'(1);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      a_rvalid_expected: assert (!(imem_rvalid && r_outstanding == '0));
      a_outstanding_max: assert (r_outstanding <= OW'(MAX_OUTSTANDING));
      a_slots_bound:     assert (w_slots_used <= 32'(DEPTH));
      a_discard_bound:   assert (r_discard <= r_outstanding);
      a_no_push_full:    assert (!(w_push && w_full && !w_pop));
      a_pc4_consistent:  assert (!instr_valid || (pc4 == pc + XLEN'(4)));
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Scenario bench for if_prefetch_buffer: a bus-slave model plus a queue-level
// reference of what decode must see, with randomized and directed stimulus.
module tb_if_prefetch_buffer;
  import if_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] pctarget = '0;
  logic        stall_d = 1'b0;
  logic        instr_valid;
  logic [31:0] instruction, pc, pc4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  always #5 clk = ~clk;

  if_prefetch_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .pctarget(pctarget), .stall_d(stall_d),
    .instr_valid(instr_valid), .instruction(instruction), .pc(pc), .pc4(pc4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference: words decode is owed (by pc) and requests the slave still owes.
  typedef struct packed { logic [31:0] addr; int epoch; } pend_t;
  logic [31:0] mq[$];
  pend_t       pend[$];
  int          epoch = 0;
  logic [31:0] m_fetch = RESET_PC;

  logic         obs_valid, obs_req, rv_seen;
  logic [31:0]  obs_pc, obs_pc4, obs_instr, obs_addr;
  logic [129:0] obs_vec, exp_vec;

  task automatic step(input bit ps, input logic [31:0] tgt, input bit st,
                      input bit g, input bit rv);
    bit          e_valid, e_req;
    logic [31:0] e_pc, e_pc4, e_instr;
    pcsrc = ps; pctarget = tgt; stall_d = st; imem_gnt = g;
    imem_rvalid = rv && (pend.size() > 0);
    imem_rdata  = (pend.size() > 0) ? (pend[0].addr ^ KEY) : 32'h0;
    @(negedge clk);
    e_valid = (mq.size() > 0) && !ps;
    e_pc    = (mq.size() > 0) ? mq[0] : 32'h0;
    e_pc4   = (mq.size() > 0) ? mq[0] + 32'd4 : 32'h0;
    e_instr = (mq.size() > 0) ? (mq[0] ^ KEY) : 32'h0000_0013;
    e_req   = !ps && (pend.size() < MAXO) && (mq.size() + pend.size() < DEPTH);
    obs_valid = instr_valid; obs_req = imem_req; obs_pc = pc; obs_pc4 = pc4;
    obs_instr = instruction; obs_addr = imem_addr;
    exp_vec = {e_valid, e_req, e_instr, e_pc, e_pc4, e_req ? m_fetch : 32'h0};
    obs_vec = {instr_valid, imem_req, instruction, pc, pc4, e_req ? imem_addr : 32'h0};
    @(posedge clk);
    rv_seen = imem_rvalid;
    if (e_valid && !st) begin
      $display("pop pc=%08h instr=%08h", e_pc, e_instr);
      void'(mq.pop_front());
    end
    if (imem_rvalid) begin
      if (!ps && pend[0].epoch == epoch) mq.push_back(pend[0].addr);
      void'(pend.pop_front());
    end
    if (ps) begin
      mq.delete();
      epoch++;
      m_fetch = {tgt[31:2], 2'b00};
    end else if (e_req && g) begin
      pend.push_back('{m_fetch, epoch});
      m_fetch += 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({instr_valid, imem_req, instruction, pc, pc4} !== {1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_outputs got v=%b r=%b i=%h pc=%h pc4=%h want v=0 r=0 i=00000013 pc=0 pc4=0",
               instr_valid, imem_req, instruction, pc, pc4);
    end
    total++;
    if (imem_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    int first_req = -1, first_valid = -1;
    for (int c = 0; c < 16; c++) begin
      step(0, 0, 0, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL stream cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
      if (first_req < 0 && obs_req) first_req = c;
      if (first_valid < 0 && obs_valid) first_valid = c;
    end
    total++;
    if (first_req < 0 || first_valid - first_req != 2) begin
      bad++; $display("FAIL first_latency got=%0d want=2 (req@%0d)", first_valid - first_req, first_req);
    end
  endtask

  task automatic test_stall();
    logic [31:0] got[$];
    bit ok;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 1, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL stall cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
    end
    total++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin
      bad++; $display("FAIL stall_full got req=%b valid=%b want req=0 valid=1", obs_req, obs_valid);
    end
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL drain cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
      if (obs_valid) got.push_back(obs_pc);
    end
    ok = (got.size() == 4);
    for (int k = 1; k < got.size(); k++) if (got[k] !== got[0] + 32'(4 * k)) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL drain_order got %0d pops first=%h want 4 consecutive", got.size(), (got.size() > 0) ? got[0] : 32'h0); end
  endtask

  task automatic test_redirect();
    int nrv = 0;
    bit got = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 1, 0);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL redir_fill cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
    end
    total++;
    if (obs_req !== 1'b0) begin bad++; $display("FAIL max_outstanding got req=%b want 0", obs_req); end
    step(1, 32'h100, 0, 1, 0);
    total++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_cycle got req=%b valid=%b want 0 0", obs_req, obs_valid);
    end
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL redir cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
      if (!got && obs_valid) begin
        got = 1'b1;
        total++;
        if (obs_pc !== 32'h100 || obs_pc4 !== 32'h104) begin
          bad++; $display("FAIL redirect_pc got pc=%h pc4=%h want 100 104", obs_pc, obs_pc4);
        end
        total++;
        if (nrv != 3) begin bad++; $display("FAIL redirect_drops got %0d responses before delivery want 3", nrv); end
      end
      if (!got && rv_seen) nrv++;
    end
    if (!got) begin total++; bad++; $display("FAIL redirect_timeout got none want pc=100"); end
  endtask

  task automatic test_redirect_same_cycle();
    bit got = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(0, 0, 0, 1, 0);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL same_fill cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
    end
    step(1, 32'h203, 0, 1, 1);
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL same_redirect got=%h want=%h", obs_vec, exp_vec); end
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL same cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
      if (!got && obs_valid) begin
        got = 1'b1;
        total++;
        if (obs_pc !== 32'h200 || obs_instr !== (32'h200 ^ KEY)) begin
          bad++; $display("FAIL same_cycle_pc got pc=%h instr=%h want 200 %h", obs_pc, obs_instr, 32'h200 ^ KEY);
        end
      end
    end
    if (!got) begin total++; bad++; $display("FAIL same_cycle_timeout got none want pc=200"); end
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    logic [31:0] got4[$];
    step(1, 32'hFFFF_FFFC, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 1);
      total++;
      if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
        bad++; $display("FAIL gnt_hold cyc=%0d got req=%b addr=%h want 1 fffffffc", c, obs_req, obs_addr);
      end
    end
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL wrap cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
      if (obs_valid) begin got.push_back(obs_pc); got4.push_back(obs_pc4); end
    end
    total++;
    if (got.size() < 2 || got[0] !== 32'hFFFF_FFFC || got4[0] !== 32'h0 || got[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_seq got n=%0d pc0=%h pc4_0=%h pc1=%h want fffffffc 0 0", got.size(),
               (got.size() > 0) ? got[0] : 32'hx, (got.size() > 0) ? got4[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    for (int c = 0; c < 20 && mq.size() != 3; c++) begin
      step(0, 0, 1, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL fill3 cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
    end
    if (mq.size() != 3) begin total++; bad++; $display("FAIL fill3_timeout got %0d entries want 3", mq.size()); end
    pcsrc = 1'b0; stall_d = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({instr_valid, imem_req, instruction, pc, pc4, imem_addr} !==
        {1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h0, RESET_PC}) begin
      bad++;
      $display("FAIL async_reset got v=%b r=%b i=%h pc=%h pc4=%h a=%h want 0 0 00000013 0 0 %h",
               instr_valid, imem_req, instruction, pc, pc4, imem_addr, RESET_PC);
    end
    mq.delete(); pend.delete(); epoch++; m_fetch = RESET_PC;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 1, 1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL restart cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
      if (!got && obs_valid) begin
        got = 1'b1;
        total++;
        if (obs_pc !== RESET_PC) begin bad++; $display("FAIL restart_pc got=%h want=%h", obs_pc, RESET_PC); end
      end
    end
    if (!got) begin total++; bad++; $display("FAIL restart_timeout got none want pc=%h", RESET_PC); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 16) == 0, $urandom, ($urandom % 3) == 0,
           ($urandom % 4) != 0, ($urandom % 4) != 0);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", c, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
